// File: rtl/rip_fifo_pkg.sv
// Shared helpers for the rip_fifo_stream FIFO.
//   cnt_width(depth) : bits needed to hold an occupancy of 0..depth
//   ptr_width(depth) : bits needed for an index 0..depth-1 (at least 1)
//   params_ok(...)   : legality of the FIFO parameter set, checked at elaboration
package rip_fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic bit params_ok(input int data_width, input int depth,
                                     input int afull_thresh, input int aempty_thresh);
        return (data_width >= 1) && (depth >= 2) &&
               (afull_thresh >= 0) && (afull_thresh <= depth) &&
               (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/rip_fifo_ptr.sv
// Wrap-around index counter, 0..DEPTH-1, for any DEPTH (explicit compare
// against the last index, no power-of-two masking).
//   clk : clock
//   rst : synchronous active-high reset (index to 0)
//   clr : synchronous clear (index to 0), has priority over inc
//   inc : advance the index by one, wrapping after DEPTH-1
//   idx : current index
module rip_fifo_ptr
    import rip_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] idx
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [PW-1:0] idx_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_reg <= '0;
        end else if (inc) begin
            idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
    end

    assign idx = idx_reg;

endmodule

// File: rtl/rip_fifo_stream.sv
// Synchronous FIFO with valid/ready on both sides and a registered
// first-word-fall-through output. The oldest word always lives in the output
// register; the remaining (up to DEPTH-1) words live in an inferred array
// with a registered read into that output register.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : synchronous clear of occupancy (r_data and array kept)
//   w_valid/w_ready/w_data : write handshake
//   r_valid/r_ready/r_data : read handshake, r_data is a register
//   count         : words held, including the output register
//   almost_full   : count >= AFULL_THRESH
//   almost_empty  : count <= AEMPTY_THRESH
//   overflow      : sticky, write attempted while w_ready=0 (not during flush)
module rip_fifo_stream
    import rip_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    localparam int CNT_W        = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow
);

    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int PW        = ptr_width(MEM_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AEMPTY_THRESH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    if (!params_ok(DATA_WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("rip_fifo_stream: illegal parameter set");
    end

    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic [DATA_WIDTH-1:0] r_data_reg;
    logic                  overflow_reg;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic          wfire;
    logic          rfire;
    logic          load_out;
    logic          mem_empty;
    logic          out_from_mem;
    logic          out_from_in;
    logic          mem_wr;
    logic [PW-1:0] rd_idx;
    logic [PW-1:0] wr_idx;

    // Handshake decode: everything depends on registered count plus flush.
    assign w_ready  = (count_reg != DEPTH_C) && !flush;
    assign r_valid  = (count_reg != '0);
    assign wfire    = w_valid && w_ready;
    assign rfire    = r_valid && r_ready && !flush;

    // The output register takes a new word when it is empty or being consumed.
    // If the array holds something, the next-oldest comes from the array;
    // otherwise an incoming write lands directly in the output register.
    assign load_out     = !r_valid || rfire;
    assign mem_empty    = (count_reg <= ONE_C);
    assign out_from_mem = load_out && !mem_empty;
    assign out_from_in  = load_out && mem_empty && wfire;
    assign mem_wr       = wfire && !out_from_in;

    rip_fifo_ptr #(.DEPTH(MEM_DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (out_from_mem),
        .idx (rd_idx)
    );

    rip_fifo_ptr #(.DEPTH(MEM_DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (mem_wr),
        .idx (wr_idx)
    );

    always_comb begin
        count_next = count_reg;
        case ({wfire, rfire})
            2'b10:   count_next = count_reg + ONE_C;
            2'b01:   count_next = count_reg - ONE_C;
            default: count_next = count_reg;
        endcase
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_idx] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_reg <= '0;
        end else if (out_from_mem) begin
            r_data_reg <= mem[rd_idx];
        end else if (out_from_in) begin
            r_data_reg <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (w_valid && !w_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_reg <= DEPTH_C)
                else $error("rip_fifo_stream: count %0d exceeds depth", count_reg);
        end
    end

    assign r_data       = r_data_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);

endmodule
